// File: rtl/avr_serial_tx.sv
// avr_serial_tx: UART-style byte serialiser towards the AVR (start, 8 data LSB first, [even parity if AVR_SERIAL_TX_PARITY_EN], stop).
// Latency: request accepted on the edge it is seen while idle; start bit appears on tx from the following cycle.
// Backpressure: busy is high while a frame is in flight or the synchronised AVR block is set; requests seen while busy are dropped.
module avr_serial_tx #(
    parameter int CLK_PER_BIT = 100,
    parameter int CTR_LEN     = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       new_data,
    input  logic       block,
    output logic       busy,
    output logic       tx
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef AVR_SERIAL_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [CTR_LEN-1:0] CTR_LAST = CTR_LEN'(CLK_PER_BIT - 1);

    state_t             state_q, state_d;
    logic [CTR_LEN-1:0] ctr_q, ctr_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               tx_q, tx_d;
    logic               block_meta_q;
    logic               block_q;

    // block comes from the AVR clock domain; two flops before it is trusted
    always_ff @(posedge clk) begin
        if (rst) begin
            block_meta_q <= 1'b0;
            block_q      <= 1'b0;
        end else begin
            block_meta_q <= block;
            block_q      <= block_meta_q;
        end
    end

    // frame state, bit timer, bit index, latched byte and the registered line
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctr_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    // next-state: tx_d always carries the level of the bit state being entered,
    // so the line changes on the same edge as the state
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        idx_d   = idx_q;
        data_d  = data_q;
        tx_d    = tx_q;

        case (state_q)
            ST_IDLE: begin
                tx_d  = 1'b1;
                ctr_d = '0;
                if (new_data && !block_q) begin
                    data_d  = data;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end

            ST_START: begin
                if (ctr_q == CTR_LAST) begin
                    ctr_d   = '0;
                    idx_d   = 3'd0;
                    state_d = ST_DATA;
                    tx_d    = data_q[0];
                end else begin
                    ctr_d = ctr_q + CTR_LEN'(1);
                end
            end

            ST_DATA: begin
                if (ctr_q == CTR_LAST) begin
                    ctr_d = '0;
                    if (idx_q == 3'd7) begin
`ifdef AVR_SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = data_q[idx_q + 3'd1];
                    end
                end else begin
                    ctr_d = ctr_q + CTR_LEN'(1);
                end
            end

`ifdef AVR_SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (ctr_q == CTR_LAST) begin
                    ctr_d   = '0;
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    ctr_d = ctr_q + CTR_LEN'(1);
                end
            end
`endif

            ST_STOP: begin
                if (ctr_q == CTR_LAST) begin
                    ctr_d   = '0;
                    state_d = ST_IDLE;
                    tx_d    = 1'b1;
                end else begin
                    ctr_d = ctr_q + CTR_LEN'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                ctr_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign busy = (state_q != ST_IDLE) | block_q;
    assign tx   = tx_q;

endmodule

// File: tb/tb_avr_serial_tx.sv
// tb_avr_serial_tx: random and directed byte requests against a timeline model of the serial line.
// Latency: model predicts the accept edge; monitor expects the start bit right after it.
// Backpressure: model tracks frame occupancy and the 2-edge block delay to decide which requests are dropped.
module tb_avr_serial_tx;

    localparam int CPB = 4;
`ifdef AVR_SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       new_data = 1'b0;
    logic       block    = 1'b0;
    logic [7:0] data     = 8'd0;
    logic       busy;
    logic       tx;

    avr_serial_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .new_data (new_data),
        .block    (block),
        .busy     (busy),
        .tx       (tx)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         e;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_n = 0;
    bit   armed = 0;
    bit   rst_edge = 0;
    bit   busy_exp = 0;
    int   fr_start = -1;
    int   fr_end = -1;
    bit   dly_a = 0;
    bit   dly_b = 0;
    int   n_acc = 0;

    function automatic void check(string nm, logic act, logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s at edge %0d: got %b, required %b", nm, edge_n, act, req);
        end
    endfunction

    // Line contents of one frame, first bit on the wire at index 0
    function automatic logic [NB-1:0] frame_bits(logic [7:0] b);
        logic [NB-1:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef AVR_SERIAL_TX_PARITY_EN
        f[9] = ^b;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // Reference model: frame occupies FL cycles from its accept edge, one idle cycle
    // must be seen before the next accept, and block reaches the decision 2 edges late
    always @(posedge clk) begin
        bit   idle_before;
        exp_t e;
        edge_n++;
        idle_before = !(fr_start >= 0 && (edge_n - 1) >= fr_start && (edge_n - 1) <= fr_end);
        rst_edge = rst;
        if (rst) begin
            armed    = 1;
            fr_start = -1;
            fr_end   = -1;
            dly_a    = 0;
            dly_b    = 0;
        end else begin
            if (new_data && idle_before && !dly_b) begin
                e.b = data;
                e.e = edge_n;
                sb.push_back(e);
                fr_start = edge_n;
                fr_end   = edge_n + FL - 1;
                n_acc++;
            end
            dly_b = dly_a;
            dly_a = block;
        end
        busy_exp = (fr_start >= 0 && edge_n >= fr_start && edge_n <= fr_end) || dly_b;
    end

    logic [NB-1:0] bits = '0;
    int            pos = 0;
    int            cnt = 0;
    bit            in_frame = 0;

    // Monitor: every cycle checks busy, and tx against either the expected frame or idle-high
    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            if (rst_edge) in_frame = 0;
            check("busy", busy, busy_exp);
            if (!in_frame && sb.size() > 0 && sb[0].e == edge_n) begin
                e        = sb.pop_front();
                bits     = frame_bits(e.b);
                in_frame = 1;
                pos      = 0;
                cnt      = 0;
            end
            if (in_frame) begin
                check("frame_bit", tx, bits[pos]);
                cnt++;
                if (cnt == CPB) begin
                    cnt = 0;
                    pos++;
                    if (pos == NB) in_frame = 0;
                end
            end else begin
                check("idle_tx", tx, 1'b1);
            end
        end
    end

    task automatic step(int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(logic [7:0] b, int hold);
        data     = b;
        new_data = 1'b1;
        step(hold);
        new_data = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(20);

        send(8'hA5, 1);
        step(FL + 5);
        send(8'h07, 1);
        step(FL + 5);

        // held request with data changing mid-frame
        data     = 8'h3C;
        new_data = 1'b1;
        step(1);
        data = 8'h55;
        step(FL + 1);
        new_data = 1'b0;
        step(FL + 5);

        // flow control hold-off and release
        block = 1'b1;
        step(3);
        send(8'hFF, 1);
        step(5);
        block    = 1'b0;
        data     = 8'hFF;
        new_data = 1'b1;
        step(3);
        new_data = 1'b0;
        step(FL + 5);

        // block raised mid-frame, kept past the stop bit
        send(8'h96, 1);
        step(10);
        block = 1'b1;
        step(FL + 10);
        block = 1'b0;
        step(5);

        // reset taken on cycle 13 of a frame, then a clean frame
        send(8'h00, 1);
        step(12);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(3);
        send(8'h81, 1);
        step(FL + 5);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) block = ~block;
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end
            send(8'($urandom), int'($urandom_range(1, 3)));
            step(int'($urandom_range(0, FL + 8)));
        end
        block = 1'b0;
        step(FL + 10);

        tests++;
        if (in_frame || sb.size() != 0) begin
            fails++;
            $display("FAIL drain: in_frame=%0d pending=%0d, required 0 and 0", in_frame, sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
